score_ram: RTL and testbench

SCORE_RAM -- requirements
Module: score_ram

---
 rtl/score_ram_pkg.sv | 12 +
 rtl/score_ram_if.sv | 20 ++
 rtl/score_ram_array.sv | 38 +++
 rtl/score_ram.sv | 115 +++++++++++
 tb/tb_score_ram.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/score_ram_pkg.sv
// Shared types and constants for the score RAM: widths, FSM state encoding
// and the default score that the clear sweep loads into odd addresses.
package score_ram_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] SCORE_DEFAULT_C = 16'd99;

  typedef enum logic {
    CLEAR = 1'b0,
    SERVE = 1'b1
  } state_t;
endpackage

// File: rtl/score_ram_if.sv
// Request/response bundle between a score RAM initiator (master) and the RAM (slave).
interface score_ram_if;
  import score_ram_pkg::*;

  logic              scoreRAM_RW;
  logic [ADDR_W-1:0] scoreRAM_Addr;
  logic [DATA_W-1:0] scoreRAM_Din;
  logic [DATA_W-1:0] scoreRAM_Dout;
  logic              ready;

  modport master (
    output scoreRAM_RW, scoreRAM_Addr, scoreRAM_Din,
    input  scoreRAM_Dout, ready
  );

  modport slave (
    input  scoreRAM_RW, scoreRAM_Addr, scoreRAM_Din,
    output scoreRAM_Dout, ready
  );
endinterface

// File: rtl/score_ram_array.sv
// DEPTH x 16 storage: one write port, one registered read-first read port.
// Out-of-range addresses drop writes and read as zero.
module score_ram_array
  import score_ram_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;
  logic              w_wr_ok;
  logic              w_rd_ok;

  assign w_wr_ok = i_we && (int'(i_waddr) < DEPTH);
  assign w_rd_ok = i_rd_en && (int'(i_raddr) < DEPTH);

  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[i_waddr] <= i_wdata;
  end

  // Read samples the pre-write word, so a same-edge write is seen one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_rdata <= '0;
    else if (w_rd_ok) r_rdata <= r_mem[i_raddr];
    else              r_rdata <= '0;
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/score_ram.sv
// Score RAM top: clear sweep FSM, write mux and read latency pipeline.
// Optional SCORE_RAM_WRSTAT_EN adds wr_count, a saturating count of write requests.
module score_ram
  import score_ram_pkg::*;
#(
  parameter int                DEPTH         = 32,
  parameter int                RD_LAT        = 2,
  parameter logic [DATA_W-1:0] SCORE_DEFAULT = SCORE_DEFAULT_C
) (
  input  logic       clk,
  input  logic       rst,
  score_ram_if.slave bus
`ifdef SCORE_RAM_WRSTAT_EN
  ,
  output logic [7:0] wr_count
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_sweep;
  logic              r_ready;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_rd_en;
  logic [DATA_W-1:0] w_rdata;
  logic [DATA_W-1:0] r_rd_p1;
  logic [DATA_W-1:0] r_rd_p2;
  logic [DATA_W-1:0] w_dout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= CLEAR;
      r_sweep <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == SERVE);
      if (r_state == CLEAR) r_sweep <= r_sweep + ADDR_W'(1);
    end
  end

  // The sweep owns the write port while clearing; the initiator owns it afterwards.
  always_comb begin
    w_state_nxt = r_state;
    w_we        = bus.scoreRAM_RW;
    w_waddr     = bus.scoreRAM_Addr;
    w_wdata     = bus.scoreRAM_Din;
    w_rd_en     = 1'b1;
    case (r_state)
      CLEAR: begin
        w_we    = 1'b1;
        w_waddr = r_sweep;
        w_wdata = r_sweep[0] ? SCORE_DEFAULT : '0;
        w_rd_en = 1'b0;
        if (r_sweep == LAST_ADDR) w_state_nxt = SERVE;
      end
      SERVE: w_state_nxt = SERVE;
    endcase
  end

  score_ram_array #(.DEPTH(DEPTH)) u_array (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_rd_en (w_rd_en),
    .i_raddr (bus.scoreRAM_Addr),
    .o_rdata (w_rdata)
  );

  // p1/p2: extra delay stages after the array's registered read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_p1 <= '0;
      r_rd_p2 <= '0;
    end else begin
      r_rd_p1 <= w_rdata;
      r_rd_p2 <= r_rd_p1;
    end
  end

  always_comb begin
    case (RD_LAT)
      1:       w_dout = w_rdata;
      3:       w_dout = r_rd_p2;
      default: w_dout = r_rd_p1;
    endcase
  end

  assign bus.scoreRAM_Dout = w_dout;
  assign bus.ready         = r_ready;

`ifdef SCORE_RAM_WRSTAT_EN
  logic       r_rw_prev;
  logic [7:0] r_wr_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rw_prev  <= 1'b0;
      r_wr_count <= '0;
    end else begin
      r_rw_prev <= bus.scoreRAM_RW;
      if ((r_state == SERVE) && bus.scoreRAM_RW && !r_rw_prev && (r_wr_count != 8'hFF))
        r_wr_count <= r_wr_count + 8'd1;
    end
  end

  assign wr_count = r_wr_count;
`endif
endmodule

// File: tb/tb_score_ram.sv
// Self-checking bench for score_ram: randomized traffic against an array model of the words.
module tb_score_ram;
  import score_ram_pkg::*;

  localparam int DEPTH  = 32;
  localparam int RD_LAT = 2;

  logic clk = 1'b0;
  logic rst;
  score_ram_if bus();
`ifdef SCORE_RAM_WRSTAT_EN
  logic [7:0] wr_count;
`endif

  score_ram #(.DEPTH(DEPTH), .RD_LAT(RD_LAT), .SCORE_DEFAULT(16'd99)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef SCORE_RAM_WRSTAT_EN
    ,
    .wr_count (wr_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [15:0] model [DEPTH];

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = (i % 2 == 1) ? 16'd99 : 16'h0000;
  endtask

  // Called at a negedge with rst high; drives a stray write while the sweep runs.
  task automatic release_and_wait(input string tag);
    int   n;
    logic clr_ok;
    n = 0;
    clr_ok = 1'b1;
    bus.scoreRAM_RW   = 1'b1;
    bus.scoreRAM_Addr = 5'd5;
    bus.scoreRAM_Din  = 16'hBEEF;
    rst = 1'b0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (bus.ready === 1'b1) break;
      if (bus.scoreRAM_Dout !== 16'h0000) clr_ok = 1'b0;
    end
    bus.scoreRAM_RW = 1'b0;
    total++;
    if (clr_ok !== 1'b1) begin
      bad++;
      $display("FAIL %s_clear_dout: Dout nonzero during sweep, required 0", tag);
    end
    total++;
    if (n !== 32 || bus.ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_ready_latency: ready after %0d cycles (ready=%b), required 32", tag, n, bus.ready);
    end
    model_clear();
  endtask

  task automatic rd(input logic [4:0] a, output logic [15:0] d);
    bus.scoreRAM_Addr = a;
    bus.scoreRAM_RW   = 1'b0;
    repeat (RD_LAT) @(negedge clk);
    d = bus.scoreRAM_Dout;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.scoreRAM_RW   = 1'b0;
    bus.scoreRAM_Addr = '0;
    bus.scoreRAM_Din  = '0;
    #2;
    total++;
    if (bus.ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready: got %b required 0", bus.ready);
    end
    total++;
    if (bus.scoreRAM_Dout !== 16'h0000) begin
      bad++;
      $display("FAIL reset_dout: got %h required 0000", bus.scoreRAM_Dout);
    end
    @(negedge clk);
    release_and_wait("reset");
  endtask

  task automatic test_defaults();
    logic [4:0]  addrs [5];
    logic [15:0] got;
    addrs = '{5'd0, 5'd1, 5'd31, 5'd5, 5'd30};
    for (int i = 0; i < 5; i++) begin
      rd(addrs[i], got);
      total++;
      if (got !== model[addrs[i]]) begin
        bad++;
        $display("FAIL default_word[%0d]: got %h required %h", addrs[i], got, model[addrs[i]]);
      end
    end
  endtask

  task automatic test_write_hold();
    bus.scoreRAM_Addr = 5'd3;
    bus.scoreRAM_Din  = 16'd42;
    bus.scoreRAM_RW   = 1'b1;
    repeat (4) @(negedge clk);
    bus.scoreRAM_RW = 1'b0;
    model[3] = 16'd42;
    repeat (RD_LAT) @(negedge clk);
    total++;
    if (bus.scoreRAM_Dout !== model[3]) begin
      bad++;
      $display("FAIL write_hold: got %h required %h", bus.scoreRAM_Dout, model[3]);
    end
    repeat (4) @(negedge clk);
    total++;
    if (bus.scoreRAM_Dout !== model[3]) begin
      bad++;
      $display("FAIL write_hold_stable: got %h required %h", bus.scoreRAM_Dout, model[3]);
    end
  endtask

  task automatic test_read_first();
    bus.scoreRAM_Addr = 5'd6;
    bus.scoreRAM_Din  = 16'h1234;
    bus.scoreRAM_RW   = 1'b1;
    @(negedge clk);
    bus.scoreRAM_RW = 1'b0;
    repeat (RD_LAT + 1) @(negedge clk);
    total++;
    if (bus.scoreRAM_Dout !== 16'h1234) begin
      bad++;
      $display("FAIL read_first_setup: got %h required 1234", bus.scoreRAM_Dout);
    end
    bus.scoreRAM_Din = 16'h5678;
    bus.scoreRAM_RW  = 1'b1;
    @(negedge clk);
    bus.scoreRAM_RW = 1'b0;
    model[6] = 16'h5678;
    repeat (RD_LAT - 1) @(negedge clk);
    total++;
    if (bus.scoreRAM_Dout !== 16'h1234) begin
      bad++;
      $display("FAIL read_first_old: got %h required 1234", bus.scoreRAM_Dout);
    end
    @(negedge clk);
    total++;
    if (bus.scoreRAM_Dout !== 16'h5678) begin
      bad++;
      $display("FAIL read_first_new: got %h required 5678", bus.scoreRAM_Dout);
    end
  endtask

  task automatic test_random();
    logic [4:0]  a;
    logic [4:0]  b;
    logic [15:0] d;
    logic [15:0] got;
    int          hold;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        a    = 5'($urandom_range(0, DEPTH - 1));
        d    = 16'($urandom);
        hold = $urandom_range(1, 3);
        bus.scoreRAM_Addr = a;
        bus.scoreRAM_Din  = d;
        bus.scoreRAM_RW   = 1'b1;
        repeat (hold) @(negedge clk);
        bus.scoreRAM_RW = 1'b0;
        model[a] = d;
      end
      b = 5'($urandom_range(0, DEPTH - 1));
      rd(b, got);
      total++;
      if (got !== model[b]) begin
        bad++;
        $display("FAIL random_read[%0d] it=%0d: got %h required %h", b, it, got, model[b]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [15:0] got;
    bus.scoreRAM_Addr = 5'd3;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (bus.ready !== 1'b0 || bus.scoreRAM_Dout !== 16'h0000) begin
      bad++;
      $display("FAIL async_reset: ready=%b Dout=%h required ready=0 Dout=0000", bus.ready, bus.scoreRAM_Dout);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    release_and_wait("mid_reset");
    for (int i = 0; i < DEPTH; i++) begin
      rd(5'(i), got);
      total++;
      if (got !== model[i]) begin
        bad++;
        $display("FAIL mid_reset_word[%0d]: got %h required %h", i, got, model[i]);
      end
    end
  endtask

`ifdef SCORE_RAM_WRSTAT_EN
  task automatic test_wrstat();
    total++;
    if (wr_count !== 8'd0) begin
      bad++;
      $display("FAIL wrstat_start: got %0d required 0", wr_count);
    end
    bus.scoreRAM_Addr = 5'd7;
    bus.scoreRAM_Din  = 16'h0007;
    for (int p = 0; p < 3; p++) begin
      bus.scoreRAM_RW = 1'b1;
      repeat (4) @(negedge clk);
      bus.scoreRAM_RW = 1'b0;
      repeat (2) @(negedge clk);
    end
    total++;
    if (wr_count !== 8'd3) begin
      bad++;
      $display("FAIL wrstat_three: got %0d required 3", wr_count);
    end
    for (int p = 0; p < 300; p++) begin
      bus.scoreRAM_RW = 1'b1;
      @(negedge clk);
      bus.scoreRAM_RW = 1'b0;
      @(negedge clk);
    end
    total++;
    if (wr_count !== 8'd255) begin
      bad++;
      $display("FAIL wrstat_saturate: got %0d required 255", wr_count);
    end
    model[7] = 16'h0007;
  endtask
`endif

  initial begin
    test_reset();
    test_defaults();
    test_write_hold();
    test_read_first();
    test_random();
    test_mid_reset();
`ifdef SCORE_RAM_WRSTAT_EN
    test_wrstat();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
